// File: rtl/pcie_client0_tx_arb.sv
// Packet-level arbiter sharing the XADM client0 TX port between the completion
// generator (req0) and the posted-write generator (req1); one whole TLP per grant.
module pcie_client0_tx_arb #(
  parameter int unsigned HDR_WD    = 128,
  parameter int unsigned DT_WD     = 64,
  parameter int unsigned CPL_PRIO  = 1,
  parameter int unsigned MAX_BEATS = 512
) (
  input  logic              core_clk,
  input  logic              core_rst_n,

  input  logic              req0_tlp_hv,
  input  logic              req0_tlp_dv,
  input  logic              req0_tlp_eot,
  input  logic [HDR_WD-1:0] req0_header_data,
  input  logic [DT_WD-1:0]  req0_tlp_data,
  input  logic [12:0]       req0_tlp_byte_len,
  output logic              req0_halt_o,

  input  logic              req1_tlp_hv,
  input  logic              req1_tlp_dv,
  input  logic              req1_tlp_eot,
  input  logic [HDR_WD-1:0] req1_header_data,
  input  logic [DT_WD-1:0]  req1_tlp_data,
  input  logic [12:0]       req1_tlp_byte_len,
  output logic              req1_halt_o,

  output logic              client0_tlp_hv_o,
  output logic              client0_tlp_dv_o,
  output logic              client0_tlp_eot_o,
  output logic [HDR_WD-1:0] client0_header_data_o,
  output logic [DT_WD-1:0]  client0_tlp_data_o,
  output logic [12:0]       client0_tlp_byte_len_o,
  input  logic              xadm_client0_halt_i,

  output logic [1:0]        grant_o,
  output logic              timeout_err_o
);

  localparam int unsigned CNT_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_grant;
  logic               r_rr_last;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_timeout_err;

  logic               w_pick0;
  logic               w_pick1;
  logic               w_dv_acc;
  logic               w_eot_acc;
  logic               w_timeout_hit;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Zero-latency path from the granted source to the core; idle drives all zeros.
  always_comb begin
    client0_tlp_hv_o       = 1'b0;
    client0_tlp_dv_o       = 1'b0;
    client0_tlp_eot_o      = 1'b0;
    client0_header_data_o  = '0;
    client0_tlp_data_o     = '0;
    client0_tlp_byte_len_o = '0;
    req0_halt_o            = 1'b1;
    req1_halt_o            = 1'b1;
    if (r_state == ST_BUSY) begin
      if (r_grant[1]) begin
        client0_tlp_hv_o       = req1_tlp_hv;
        client0_tlp_dv_o       = req1_tlp_dv;
        client0_tlp_eot_o      = req1_tlp_eot;
        client0_header_data_o  = req1_header_data;
        client0_tlp_data_o     = req1_tlp_data;
        client0_tlp_byte_len_o = req1_tlp_byte_len;
        req1_halt_o            = xadm_client0_halt_i;
      end else begin
        client0_tlp_hv_o       = req0_tlp_hv;
        client0_tlp_dv_o       = req0_tlp_dv;
        client0_tlp_eot_o      = req0_tlp_eot;
        client0_header_data_o  = req0_header_data;
        client0_tlp_data_o     = req0_tlp_data;
        client0_tlp_byte_len_o = req0_tlp_byte_len;
        req0_halt_o            = xadm_client0_halt_i;
      end
    end
  end

  // Arbitration: r_rr_last=1 means req1 went last, so req0 wins a tie.
  always_comb begin
    w_pick0 = 1'b0;
    if (CPL_PRIO != 0) begin
      w_pick0 = req0_tlp_hv;
    end else begin
      w_pick0 = req0_tlp_hv & (~req1_tlp_hv | r_rr_last);
    end
    w_pick1 = req1_tlp_hv & ~w_pick0;
  end

  always_comb begin
    w_dv_acc      = client0_tlp_dv_o & ~xadm_client0_halt_i;
    w_eot_acc     = w_dv_acc & client0_tlp_eot_o;
    w_cnt_inc     = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + CNT_W'(1);
    w_timeout_hit = w_dv_acc & ~client0_tlp_eot_o & (32'(w_cnt_inc) >= MAX_BEATS);
  end

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= 2'b00;
      r_rr_last     <= 1'b1;
      r_beat_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick0 | w_pick1) begin
            r_grant <= {w_pick1, w_pick0};
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_dv_acc) begin
            r_beat_cnt <= w_cnt_inc;
          end
          if (w_timeout_hit) begin
            r_timeout_err <= 1'b1;
          end
          // Grant is held through halts; only an accepted eot releases it.
          if (w_eot_acc) begin
            r_rr_last  <= r_grant[1];
            r_grant    <= 2'b00;
            r_beat_cnt <= '0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign timeout_err_o = r_timeout_err;

endmodule

// File: tb/tb_pcie_client0_tx_arb.sv
// Directed bench for pcie_client0_tx_arb: round-robin/timeout instance plus a
// strict-priority instance, shared stimulus, scoreboard of beats/headers/grants.
module tb_pcie_client0_tx_arb;

  localparam int unsigned HDR_WD = 128;
  localparam int unsigned DT_WD  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        hv, dv, eot;
  logic [HDR_WD-1:0] hdr [2];
  logic [DT_WD-1:0]  dat [2];
  logic [12:0]       blen [2];
  logic              xhalt;

  logic              rr_h0, rr_h1, rr_hv, rr_dv, rr_eot, rr_err;
  logic [HDR_WD-1:0] rr_hdr;
  logic [DT_WD-1:0]  rr_dat;
  logic [12:0]       rr_blen;
  logic [1:0]        rr_gnt;
  logic              sp_h0, sp_h1, sp_hv, sp_dv, sp_eot, sp_err;
  logic [HDR_WD-1:0] sp_hdr;
  logic [DT_WD-1:0]  sp_dat;
  logic [12:0]       sp_blen;
  logic [1:0]        sp_gnt;

  pcie_client0_tx_arb #(.HDR_WD(HDR_WD), .DT_WD(DT_WD), .CPL_PRIO(0), .MAX_BEATS(16)) u_rr (
    .core_clk(clk), .core_rst_n(rst_n),
    .req0_tlp_hv(hv[0]), .req0_tlp_dv(dv[0]), .req0_tlp_eot(eot[0]),
    .req0_header_data(hdr[0]), .req0_tlp_data(dat[0]), .req0_tlp_byte_len(blen[0]),
    .req0_halt_o(rr_h0),
    .req1_tlp_hv(hv[1]), .req1_tlp_dv(dv[1]), .req1_tlp_eot(eot[1]),
    .req1_header_data(hdr[1]), .req1_tlp_data(dat[1]), .req1_tlp_byte_len(blen[1]),
    .req1_halt_o(rr_h1),
    .client0_tlp_hv_o(rr_hv), .client0_tlp_dv_o(rr_dv), .client0_tlp_eot_o(rr_eot),
    .client0_header_data_o(rr_hdr), .client0_tlp_data_o(rr_dat),
    .client0_tlp_byte_len_o(rr_blen), .xadm_client0_halt_i(xhalt),
    .grant_o(rr_gnt), .timeout_err_o(rr_err)
  );

  pcie_client0_tx_arb #(.HDR_WD(HDR_WD), .DT_WD(DT_WD), .CPL_PRIO(1), .MAX_BEATS(512)) u_sp (
    .core_clk(clk), .core_rst_n(rst_n),
    .req0_tlp_hv(hv[0]), .req0_tlp_dv(dv[0]), .req0_tlp_eot(eot[0]),
    .req0_header_data(hdr[0]), .req0_tlp_data(dat[0]), .req0_tlp_byte_len(blen[0]),
    .req0_halt_o(sp_h0),
    .req1_tlp_hv(hv[1]), .req1_tlp_dv(dv[1]), .req1_tlp_eot(eot[1]),
    .req1_header_data(hdr[1]), .req1_tlp_data(dat[1]), .req1_tlp_byte_len(blen[1]),
    .req1_halt_o(sp_h1),
    .client0_tlp_hv_o(sp_hv), .client0_tlp_dv_o(sp_dv), .client0_tlp_eot_o(sp_eot),
    .client0_header_data_o(sp_hdr), .client0_tlp_data_o(sp_dat),
    .client0_tlp_byte_len_o(sp_blen), .xadm_client0_halt_i(xhalt),
    .grant_o(sp_gnt), .timeout_err_o(sp_err)
  );

  // Observed view follows whichever instance the current test targets.
  logic              use_sp;
  logic [1:0]        m_halt, m_gnt;
  logic              m_hv, m_dv;
  logic [HDR_WD-1:0] m_hdr;
  logic [DT_WD-1:0]  m_dat;
  logic [12:0]       m_blen;
  assign m_halt = use_sp ? {sp_h1, sp_h0} : {rr_h1, rr_h0};
  assign m_gnt  = use_sp ? sp_gnt  : rr_gnt;
  assign m_hv   = use_sp ? sp_hv   : rr_hv;
  assign m_dv   = use_sp ? sp_dv   : rr_dv;
  assign m_hdr  = use_sp ? sp_hdr  : rr_hdr;
  assign m_dat  = use_sp ? sp_dat  : rr_dat;
  assign m_blen = use_sp ? sp_blen : rr_blen;

  int checks = 0;
  int failures = 0;
  int pend[2], len[2], idx[2], tno[2], exp_tno[2];
  int acc_cnt;
  logic [DT_WD-1:0]  exp_dat[$];
  logic [HDR_WD-1:0] exp_hdr[$];
  logic [12:0]       exp_blen[$];
  logic [1:0]        exp_gnt[$], obs_gnt[$];
  logic [1:0]        last_gnt;

  function automatic logic [DT_WD-1:0] mk_dat(int s, int t, int i);
    return {16'hD000 + 16'(s), 16'(t), 32'(i)};
  endfunction

  function automatic logic [HDR_WD-1:0] mk_hdr(int s, int t, int n);
    return {16'hE000 + 16'(s), 16'(t), 32'(n), 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tlp(input int s, input int n);
    for (int i = 0; i < n; i++) exp_dat.push_back(mk_dat(s, exp_tno[s], i));
    exp_hdr.push_back(mk_hdr(s, exp_tno[s], n));
    exp_blen.push_back(13'(n * 8));
    exp_tno[s]++;
  endtask

  task automatic drive();
    for (int s = 0; s < 2; s++) begin
      if (pend[s] > 0) begin
        hv[s]   = (idx[s] == 0);
        dv[s]   = 1'b1;
        eot[s]  = (idx[s] == len[s] - 1);
        hdr[s]  = mk_hdr(s, tno[s], len[s]);
        dat[s]  = mk_dat(s, tno[s], idx[s]);
        blen[s] = 13'(len[s] * 8);
      end else begin
        hv[s] = 1'b0; dv[s] = 1'b0; eot[s] = 1'b0;
        hdr[s] = '0; dat[s] = '0; blen[s] = '0;
      end
    end
  endtask

  // One clock: monitor/score at negedge, then advance the source models after posedge.
  task automatic tick();
    logic [1:0] a;
    @(negedge clk);
    a = 2'b00;
    for (int s = 0; s < 2; s++)
      if (pend[s] > 0 && m_halt[s] === 1'b0) a[s] = 1'b1;
    if (m_dv === 1'b1 && xhalt === 1'b0) begin
      acc_cnt++;
      chk("beat_expected", 128'(exp_dat.size() != 0), 128'(1));
      if (exp_dat.size() != 0) chk("beat_data", 128'(m_dat), 128'(exp_dat.pop_front()));
    end
    if (m_hv === 1'b1 && xhalt === 1'b0) begin
      chk("hdr_expected", 128'(exp_hdr.size() != 0), 128'(1));
      if (exp_hdr.size() != 0) begin
        chk("hdr_data", 128'(m_hdr), 128'(exp_hdr.pop_front()));
        chk("byte_len", 128'(m_blen), 128'(exp_blen.pop_front()));
      end
    end
    if (m_gnt !== last_gnt) begin
      obs_gnt.push_back(m_gnt);
      last_gnt = m_gnt;
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (a[s]) begin
        if (idx[s] == len[s] - 1) begin
          idx[s] = 0; pend[s]--; tno[s]++;
        end else begin
          idx[s]++;
        end
      end
    end
    drive();
  endtask

  task automatic run_done(input string tag);
    for (int k = 0; k < 80 && (pend[0] + pend[1]) > 0; k++) tick();
    chk({tag, "_done"}, 128'(pend[0] + pend[1]), 128'(0));
    tick(); tick();
    chk({tag, "_sb_empty"}, 128'(exp_dat.size() + exp_hdr.size()), 128'(0));
  endtask

  task automatic cmp_trace(input string tag);
    chk({tag, "_trace_len"}, 128'(obs_gnt.size()), 128'(exp_gnt.size()));
    for (int i = 0; i < exp_gnt.size() && i < obs_gnt.size(); i++)
      chk({tag, "_grant_seq"}, 128'(obs_gnt[i]), 128'(exp_gnt[i]));
    obs_gnt.delete();
    exp_gnt.delete();
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    obs_gnt.delete();
    last_gnt = 2'b00;
    acc_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0; xhalt = 1'b0; use_sp = 1'b0; acc_cnt = 0; last_gnt = 2'b00;
    for (int s = 0; s < 2; s++) begin
      pend[s] = 0; len[s] = 4; idx[s] = 0; tno[s] = 0; exp_tno[s] = 0;
    end

    // T1 + T2: both sources requesting through reset, round-robin afterwards.
    pend[0] = 2; pend[1] = 1;
    push_tlp(0, 4); push_tlp(1, 4); push_tlp(0, 4);
    drive();
    tick(); tick(); tick();
    chk("t1_rr_grant", 128'(rr_gnt), 128'(2'b00));
    chk("t1_rr_halts", 128'({rr_h1, rr_h0}), 128'(2'b11));
    chk("t1_rr_hvdv", 128'({rr_hv, rr_dv}), 128'(2'b00));
    chk("t1_rr_err", 128'(rr_err), 128'(0));
    chk("t1_sp_grant", 128'(sp_gnt), 128'(2'b00));
    chk("t1_sp_halts", 128'({sp_h1, sp_h0}), 128'(2'b11));
    chk("t1_sp_hvdv", 128'({sp_hv, sp_dv}), 128'(2'b00));
    obs_gnt.delete();
    last_gnt = 2'b00;
    rst_n = 1'b1;
    run_done("t2");
    exp_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    cmp_trace("t2");

    // T3: strict priority keeps req1 waiting while req0 has TLPs queued.
    use_sp = 1'b1;
    rst_pulse();
    pend[0] = 3; len[0] = 2; pend[1] = 1; len[1] = 2;
    push_tlp(0, 2); push_tlp(0, 2); push_tlp(0, 2); push_tlp(1, 2);
    drive();
    run_done("t3");
    exp_gnt = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    cmp_trace("t3");

    // T4: core halts on req1's eot; grant and eot must hold.
    use_sp = 1'b0;
    rst_pulse();
    pend[1] = 1; len[1] = 8;
    push_tlp(1, 8);
    drive();
    for (int k = 0; k < 40 && !(idx[1] == 7 && rr_gnt == 2'b10); k++) tick();
    xhalt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_grant_held", 128'(rr_gnt), 128'(2'b10));
      chk("t4_eot_shown", 128'({rr_dv, rr_eot}), 128'(2'b11));
      chk("t4_halts", 128'({rr_h1, rr_h0}), 128'(2'b11));
      tick();
    end
    chk("t4_beats_before", 128'(acc_cnt), 128'(7));
    xhalt = 1'b0;
    tick();
    #1;
    chk("t4_grant_rel", 128'(rr_gnt), 128'(2'b00));
    chk("t4_beats", 128'(acc_cnt), 128'(8));
    run_done("t4");
    exp_gnt = '{2'b10, 2'b00};
    cmp_trace("t4");

    // T5: 22-beat TLP trips the 16-beat timeout, sticky until reset.
    rst_pulse();
    pend[0] = 1; len[0] = 22;
    push_tlp(0, 22);
    drive();
    for (int k = 0; k < 60 && acc_cnt < 15; k++) tick();
    #1;
    chk("t5_err_at15", 128'(rr_err), 128'(0));
    tick();
    #1;
    chk("t5_beats16", 128'(acc_cnt), 128'(16));
    chk("t5_err_at16", 128'(rr_err), 128'(1));
    chk("t5_grant_held", 128'(rr_gnt), 128'(2'b01));
    run_done("t5");
    chk("t5_err_after_eot", 128'(rr_err), 128'(1));
    chk("t5_grant_idle", 128'(rr_gnt), 128'(2'b00));
    rst_pulse();
    chk("t5_err_reset", 128'(rr_err), 128'(0));

    // T6: reset lands mid-TLP; outputs drop, then a fresh req1 TLP goes through.
    pend[0] = 1; len[0] = 6;
    push_tlp(0, 6);
    drive();
    for (int k = 0; k < 40 && acc_cnt < 3; k++) tick();
    chk("t6_beats_pre", 128'(acc_cnt), 128'(3));
    rst_n = 1'b0;
    xhalt = 1'b1;
    tick();
    #1;
    chk("t6_grant", 128'(rr_gnt), 128'(2'b00));
    chk("t6_ctl", 128'({rr_hv, rr_dv, rr_eot}), 128'(3'b000));
    chk("t6_hdr", 128'(rr_hdr), 128'(0));
    chk("t6_dat", 128'(rr_dat), 128'(0));
    chk("t6_blen", 128'(rr_blen), 128'(0));
    chk("t6_halts", 128'({rr_h1, rr_h0}), 128'(2'b11));
    pend[0] = 0; idx[0] = 0; tno[0]++;
    exp_dat.delete(); exp_hdr.delete(); exp_blen.delete();
    drive();
    xhalt = 1'b0;
    rst_pulse();
    pend[1] = 1; len[1] = 3;
    push_tlp(1, 3);
    drive();
    run_done("t6");
    exp_gnt = '{2'b10, 2'b00};
    cmp_trace("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
